// File: rtl/scnn_pkg.sv
// Shared types and constants for the SCNN processing-element control path.
package scnn_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 8;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Number of LANES-wide chunks needed to hold n entries (ceil(n / LANES)).
    function automatic idx_t chunk_count(input idx_t n);
        logic [IDX_W:0] t;
        t = {1'b0, n} + (IDX_W + 1)'(LANES - 1);
        return idx_t'(t / (IDX_W + 1)'(LANES));
    endfunction

endpackage

// File: rtl/scnn_lane_mask.sv
// Valid-lane mask for one chunk: lanes 0..r-1 set, r = min(LANES, count - chunk*LANES).
module scnn_lane_mask
    import scnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  idx_t              count,
    input  logic [ADDR_W-1:0] chunk,
    output logic [LANES-1:0]  mask
);

    localparam int unsigned W = IDX_W + ADDR_W + 1;

    logic [W-1:0] base;
    logic [W-1:0] cnt_w;
    logic [W-1:0] rem;

    // Remaining entries past the chunk base; lanes below that count are valid.
    always_comb begin
        base  = W'(chunk) * W'(LANES);
        cnt_w = W'(count);
        rem   = '0;
        mask  = '0;
        if (cnt_w > base) begin
            rem = cnt_w - base;
            for (int l = 0; l < LANES; l++) begin
                mask[l] = (rem > W'(l));
            end
        end
    end

endmodule

// File: rtl/scnn_pe_scheduler.sv
// Chunk-pair sequencer for one SCNN PE: weight chunks outer, input chunks inner.
// Optional performance counters are built when SCNN_SCHED_PERF_EN is defined.
module scnn_pe_scheduler
    import scnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IDX_W-1:0]         num_wt,
    input  logic [IDX_W-1:0]         num_ip,
    output logic                     wt_rd_en,
    output logic                     ip_rd_en,
    output logic [ADDR_W-1:0]        wt_chunk_addr,
    output logic [ADDR_W-1:0]        ip_chunk_addr,
    output logic [IDX_W-1:0]         offset_wt,
    output logic [IDX_W-1:0]         offset_ip,
    input  logic [IDX_W-1:0]         last_ind_wts,
    input  logic [IDX_W-1:0]         last_ind_ips,
    output logic [LANES-1:0]         wt_lane_mask,
    output logic [LANES-1:0]         ip_lane_mask,
    output logic [LANES*LANES-1:0]   prod_mask,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              perf_busy_cyc,
    output logic [31:0]              perf_stall_cyc
);

    sched_state_t      state_q, state_d;
    idx_t              num_wt_q, num_wt_d;
    idx_t              num_ip_q, num_ip_d;
    idx_t              nwc_q, nwc_d;
    idx_t              nic_q, nic_d;
    logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
    logic [ADDR_W-1:0] ip_addr_q, ip_addr_d;
    idx_t              off_wt_q, off_wt_d;
    idx_t              off_ip_q, off_ip_d;

    logic ip_last;
    logic wt_last;

    assign ip_last = (idx_t'(ip_addr_q) + idx_t'(1)) == nic_q;
    assign wt_last = (idx_t'(wt_addr_q) + idx_t'(1)) == nwc_q;

    // Next-state: latch counts on start, advance chunk pair on handshake.
    always_comb begin
        state_d   = state_q;
        num_wt_d  = num_wt_q;
        num_ip_d  = num_ip_q;
        nwc_d     = nwc_q;
        nic_d     = nic_q;
        wt_addr_d = wt_addr_q;
        ip_addr_d = ip_addr_q;
        off_wt_d  = off_wt_q;
        off_ip_d  = off_ip_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_wt_d  = num_wt;
                    num_ip_d  = num_ip;
                    nwc_d     = chunk_count(num_wt);
                    nic_d     = chunk_count(num_ip);
                    wt_addr_d = '0;
                    ip_addr_d = '0;
                    off_wt_d  = '0;
                    off_ip_d  = '0;
                    state_d   = (num_wt == '0 || num_ip == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                if (op_ready) begin
                    if (!ip_last) begin
                        ip_addr_d = ip_addr_q + ADDR_W'(1);
                        off_ip_d  = last_ind_ips + idx_t'(1);
                        state_d   = FETCH;
                    end else if (!wt_last) begin
                        ip_addr_d = '0;
                        off_ip_d  = '0;
                        wt_addr_d = wt_addr_q + ADDR_W'(1);
                        off_wt_d  = last_ind_wts + idx_t'(1);
                        state_d   = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            num_wt_q  <= '0;
            num_ip_q  <= '0;
            nwc_q     <= '0;
            nic_q     <= '0;
            wt_addr_q <= '0;
            ip_addr_q <= '0;
            off_wt_q  <= '0;
            off_ip_q  <= '0;
        end else begin
            state_q   <= state_d;
            num_wt_q  <= num_wt_d;
            num_ip_q  <= num_ip_d;
            nwc_q     <= nwc_d;
            nic_q     <= nic_d;
            wt_addr_q <= wt_addr_d;
            ip_addr_q <= ip_addr_d;
            off_wt_q  <= off_wt_d;
            off_ip_q  <= off_ip_d;
        end
    end

    assign wt_rd_en      = (state_q == FETCH);
    assign ip_rd_en      = (state_q == FETCH);
    assign op_valid      = (state_q == ISSUE);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign wt_chunk_addr = wt_addr_q;
    assign ip_chunk_addr = ip_addr_q;
    assign offset_wt     = off_wt_q;
    assign offset_ip     = off_ip_q;

    scnn_lane_mask #(
        .ADDR_W (ADDR_W)
    ) u_wt_mask (
        .count (num_wt_q),
        .chunk (wt_addr_q),
        .mask  (wt_lane_mask)
    );

    scnn_lane_mask #(
        .ADDR_W (ADDR_W)
    ) u_ip_mask (
        .count (num_ip_q),
        .chunk (ip_addr_q),
        .mask  (ip_lane_mask)
    );

    // Outer product of the two lane masks, weight lane major.
    always_comb begin
        prod_mask = '0;
        for (int f = 0; f < LANES; f++) begin
            for (int i = 0; i < LANES; i++) begin
                prod_mask[f*LANES+i] = wt_lane_mask[f] & ip_lane_mask[i];
            end
        end
    end

`ifdef SCNN_SCHED_PERF_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        perf_clr;

    assign perf_clr = (state_q == IDLE) && start;

    // Saturating busy/stall counters, cleared by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (busy && busy_cnt_q != '1) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (op_valid && !op_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_busy_cyc  = busy_cnt_q;
    assign perf_stall_cyc = stall_cnt_q;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_scnn_pe_scheduler.sv
// Self-checking bench for scnn_pe_scheduler: directed sweeps against a chunk-list model.
module tb_scnn_pe_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, op_ready;
    logic [7:0]  num_wt, num_ip, last_ind_wts, last_ind_ips;
    logic        wt_rd_en, ip_rd_en, op_valid, busy, done;
    logic [5:0]  wt_chunk_addr, ip_chunk_addr;
    logic [7:0]  offset_wt, offset_ip;
    logic [3:0]  wt_lane_mask, ip_lane_mask;
    logic [15:0] prod_mask;
    logic [31:0] perf_busy_cyc, perf_stall_cyc;

    int nvec = 0;
    int nerr = 0;
    int cap_prod[256], cap_offwt[256], cap_offip[256], cap_wm[256], cap_im[256];

    always #5 clk = ~clk;

    scnn_pe_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_wt         (num_wt),
        .num_ip         (num_ip),
        .wt_rd_en       (wt_rd_en),
        .ip_rd_en       (ip_rd_en),
        .wt_chunk_addr  (wt_chunk_addr),
        .ip_chunk_addr  (ip_chunk_addr),
        .offset_wt      (offset_wt),
        .offset_ip      (offset_ip),
        .last_ind_wts   (last_ind_wts),
        .last_ind_ips   (last_ind_ips),
        .wt_lane_mask   (wt_lane_mask),
        .ip_lane_mask   (ip_lane_mask),
        .prod_mask      (prod_mask),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .busy           (busy),
        .done           (done),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Valid lanes of a chunk: min(4, count - 4*chunk) low bits set.
    function automatic int lane_mask(input int count, input int chunk);
        int r;
        r = count - 4 * chunk;
        if (r > 4) r = 4;
        if (r < 0) r = 0;
        return (1 << r) - 1;
    endfunction

    function automatic int outer(input int wm, input int im);
        int p = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                if (wm[f] && im[i]) p |= (1 << (f * 4 + i));
        return p;
    endfunction

    // Stimulus for the coordinate block's last-index feedback at chunk pair (w,i).
    function automatic int lip(input int w, input int i);
        return (9 + 7 * i + 20 * w) & 255;
    endfunction

    function automatic int lwt(input int w, input int i);
        return (2 + i + 11 * w) & 255;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " rd_en"},   {30'd0, wt_rd_en, ip_rd_en}, 0);
        chk({tag, " addr"},    {20'd0, wt_chunk_addr, ip_chunk_addr}, 0);
        chk({tag, " offsets"}, {16'd0, offset_wt, offset_ip}, 0);
        chk({tag, " masks"},   {8'd0, wt_lane_mask, ip_lane_mask, prod_mask}, 0);
        chk({tag, " ctl"},     {29'd0, op_valid, busy, done}, 0);
        chk({tag, " perf"},    perf_busy_cyc | perf_stall_cyc, 0);
    endtask

    // One sweep from start; optional stall (ready low) at one issue, optional reset abort.
    task automatic sweep(input int nw, input int ni, input int stall_idx, input int stall_len,
                         input int abort_idx);
        int nwc, nic, idx, ew, ei, wm, im, st;
        nwc = (nw == 0 || ni == 0) ? 0 : (nw + 3) / 4;
        nic = (ni + 3) / 4;
        idx = 0;
        start = 1'b1; num_wt = 8'(nw); num_ip = 8'(ni);
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < nwc; w++) begin
            for (int i = 0; i < nic; i++) begin
                ew = (w == 0) ? 0 : (lwt(w - 1, nic - 1) + 1) & 255;
                ei = (i == 0) ? 0 : (lip(w, i - 1) + 1) & 255;
                wm = lane_mask(nw, w);
                im = lane_mask(ni, i);
                // Read-strobe cycle.
                chk("fetch rd_en", {30'd0, wt_rd_en, ip_rd_en}, 3);
                chk("fetch ctl", {29'd0, op_valid, busy, done}, 2);
                chk("fetch addr", {20'd0, wt_chunk_addr, ip_chunk_addr}, (w << 6) | i);
                @(negedge clk);
                st = (idx == stall_idx) ? stall_len : 0;
                for (int s = 0; s <= st; s++) begin
                    chk("issue rd_en", {30'd0, wt_rd_en, ip_rd_en}, 0);
                    chk("issue ctl", {29'd0, op_valid, busy, done}, 6);
                    chk("issue addr", {20'd0, wt_chunk_addr, ip_chunk_addr}, (w << 6) | i);
                    chk("issue offset_wt", 32'(offset_wt), ew);
                    chk("issue offset_ip", 32'(offset_ip), ei);
                    chk("issue wt_mask", 32'(wt_lane_mask), wm);
                    chk("issue ip_mask", 32'(ip_lane_mask), im);
                    chk("issue prod_mask", 32'(prod_mask), outer(wm, im));
                    if (s == 0) begin
                        cap_prod[idx] = prod_mask; cap_offwt[idx] = offset_wt;
                        cap_offip[idx] = offset_ip; cap_wm[idx] = wt_lane_mask;
                        cap_im[idx] = ip_lane_mask;
                    end
                    if (idx == abort_idx) begin
                        rst = 1'b1; op_ready = 1'b0;
                        @(negedge clk);
                        chk_zero("abort");
                        rst = 1'b0; op_ready = 1'b1;
                        @(negedge clk);
                        chk_zero("after abort");
                        return;
                    end
                    last_ind_ips = 8'(lip(w, i));
                    last_ind_wts = 8'(lwt(w, i));
                    if (s < st) begin
                        op_ready = 1'b0;
                        // A start pulse while busy must not disturb the latched counts.
                        start = (s == 0); num_wt = 8'd99; num_ip = 8'd99;
                    end else begin
                        op_ready = 1'b1; start = 1'b0;
                        num_wt = 8'(nw); num_ip = 8'(ni);
                    end
                    @(negedge clk);
                end
                start = 1'b0;
                idx++;
            end
        end
        chk("done ctl", {29'd0, op_valid, busy, done}, 3);
        chk("done rd_en", {30'd0, wt_rd_en, ip_rd_en}, 0);
        @(negedge clk);
        chk("idle ctl", {29'd0, op_valid, busy, done}, 0);
`ifdef SCNN_SCHED_PERF_EN
        chk("perf_busy", perf_busy_cyc, 2 * idx + ((stall_idx < idx) ? stall_len : 0) + 1);
        chk("perf_stall", perf_stall_cyc, (stall_idx < idx) ? stall_len : 0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_ready = 1'b1;
        num_wt = '0; num_ip = '0; last_ind_wts = '0; last_ind_ips = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single full chunk pair.
        sweep(4, 4, -1, 0, -1);
        chk("4x4 prod literal", cap_prod[0], 32'hFFFF);
        chk("4x4 offsets literal", (cap_offwt[0] << 8) | cap_offip[0], 0);

        // 2x2 chunks with partial tails, 3-cycle backpressure on the third issue.
        sweep(5, 6, 2, 3, -1);
        chk("5x6 ip mask i1", cap_im[1], 4'b0011);
        chk("5x6 wt mask w1", cap_wm[2], 4'b0001);
        chk("5x6 final prod", cap_prod[3], 32'h0003);
        chk("5x6 offset_ip chain", cap_offip[1], 10);
        chk("5x6 offset_wt chain", cap_offwt[2], 4);
        chk("5x6 offset_ip rewind", cap_offip[2], 0);
`ifdef SCNN_SCHED_PERF_EN
        chk("5x6 stall literal", perf_stall_cyc, 3);
`endif

        // Zero counts finish immediately with no reads or issues.
        sweep(7, 0, -1, 0, -1);
        sweep(0, 3, -1, 0, -1);

        // Reset mid-sweep, then a clean rerun from zero offsets.
        sweep(8, 8, -1, 0, 1);
        sweep(8, 8, -1, 0, -1);
        chk("rerun offset_ip", cap_offip[1], 10);
        chk("rerun offset start", (cap_offwt[0] << 8) | cap_offip[0], 0);

        // Widest address range and offset wrap.
        sweep(255, 9, 100, 2, -1);
        chk("255 last wt mask", cap_wm[63 * 3], 4'b0111);
        chk("255 last ip mask", cap_im[2], 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/scnn_pe_scheduler.md
# scnn_pe_scheduler

Sequencing controller for one SCNN processing element. It walks the compressed weight and input index buffers in 4-entry chunks, weight chunk outer and input chunk inner. For each chunk pair it drives the buffer read addresses, the `offset_wt`/`offset_ip` values consumed by the output-coordinate block, and a 16-lane product-valid mask. It sits between the PE's compressed buffers and the multiplier array / coordinate / accumulator path.

## Interface
- `LANES`, 4: entries per chunk; the product array is LANES×LANES.
- `IDX_W`, 8: width of indices, offsets and counts.
- `ADDR_W`, 6: chunk-address width for both buffers.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE.
- `num_wt`  in  IDX_W  nonzero weight count, sampled at `start`.
- `num_ip`  in  IDX_W  nonzero input count, sampled at `start`.
- `wt_rd_en`, `ip_rd_en`  out  1  buffer read strobes; read data returns the next cycle.
- `wt_chunk_addr`, `ip_chunk_addr`  out  ADDR_W  chunk addresses.
- `offset_wt`, `offset_ip`  out  IDX_W  running offsets to the coordinate block.
- `last_ind_wts`, `last_ind_ips`  in  IDX_W  last decoded index of the current chunk, from the coordinate block.
- `wt_lane_mask`, `ip_lane_mask`  out  LANES  valid lanes of the current chunk.
- `prod_mask`  out  LANES*LANES  bit f*LANES+i = `wt_lane_mask[f] & ip_lane_mask[i]`.
- `op_valid`  out  1  chunk pair presented.
- `op_ready`  in  1  downstream accepts.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at sweep end.
- `perf_busy_cyc`, `perf_stall_cyc`  out  32  performance counters (see Configuration).

## Operation
- States:
  - IDLE: `start` latches the counts. Chunk totals are `nwc = ceil(num_wt/LANES)` and `nic = ceil(num_ip/LANES)`. If either count is 0, go to DONE; else go to FETCH.
  - FETCH: assert `wt_rd_en` and `ip_rd_en` for one cycle at the current addresses, then go to ISSUE.
  - ISSUE: assert `op_valid`. Hold until `op_valid && op_ready`, then advance.
  - DONE: pulse `done`, return to IDLE.
- Advance on handshake:
  - If the input chunk is not the last: `ip_chunk_addr`+1 and `offset_ip <= last_ind_ips + 1`.
  - Else if the weight chunk is not the last: `ip_chunk_addr <= 0`, `offset_ip <= 0`, `wt_chunk_addr`+1, `offset_wt <= last_ind_wts + 1`.
  - Else go to DONE.
  - In the first two cases, go to FETCH.
- Lane masks: lanes 0..r-1 are set, where r = min(LANES, count − chunk×LANES).
- Offsets are IDX_W-bit and wrap mod 2^IDX_W; no overflow flag.
- `offset_wt`/`offset_ip` and the addresses reset to 0 at each `start`.

## Timing
- Reset values: all outputs 0; state is IDLE; perf counters are 0.
- `start` at cycle 0 → FETCH at cycle 1 → `op_valid` at cycle 2.
- After a handshake at cycle k: next `op_valid` at k+2. Peak rate is one chunk pair per 2 cycles.
- While `op_valid && !op_ready`: all outputs are held stable.
- `busy` is high from FETCH through DONE inclusive. `done` is high only in DONE.
- Zero count: `start` at cycle 0 → `done` at cycle 1. No `op_valid` or read strobes are issued.
- `rst` mid-sweep: IDLE at the next edge, outputs at reset values, no `done`.
- `start` while not IDLE: ignored; the latched counts are unchanged.

## Configuration
- `SCNN_SCHED_PERF_EN` defined:
  - `perf_busy_cyc` increments every cycle `busy` = 1.
  - `perf_stall_cyc` increments every cycle `op_valid && !op_ready`.
  - Both clear on `rst` or `start`, and saturate at all-ones.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `scnn_pkg` holds:
  - `LANES`, `IDX_W`;
  - state enum `sched_state_t` {IDLE, FETCH, ISSUE, DONE};
  - typedef `idx_t` (logic [IDX_W-1:0]).
- Sub-module `scnn_lane_mask`: combinational count + chunk index → LANES-bit mask. Instantiated twice (weights, inputs).

## Test plan
- num_wt=4, num_ip=4, `op_ready`=1, `start` at cycle 0 → one `op_valid` at cycle 2 with `prod_mask`=16'hFFFF, offsets 0/0; `done` at cycle 3.
- num_wt=5, num_ip=6 → four issues in order (w0,i0),(w0,i1),(w1,i0),(w1,i1):
  - `ip_lane_mask` for i1 = 4'b0011; `wt_lane_mask` for w1 = 4'b0001.
  - Final `prod_mask` = 16'h0003.
- Offset chaining, same sweep:
  - `last_ind_ips`=9 at (w0,i0) handshake → `offset_ip`=10 at (w0,i1).
  - `last_ind_wts`=3 at (w0,i1) → `offset_wt`=4 and `offset_ip`=0 at (w1,i0).
- Backpressure: `op_ready` low for 3 cycles during ISSUE → addresses, offsets and masks constant; with PERF_EN, `perf_stall_cyc`=3.
- num_ip=0 → `done` one cycle after `start`; zero read strobes and zero `op_valid`.
- `rst` asserted in the second ISSUE of a 2×2 sweep → IDLE and all outputs 0 next cycle; a new `start` then runs a full sweep from offsets 0.
